// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encodings and opcode-class helpers for alu_seq
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'd0,
        OP_XOR   = 4'd1,
        OP_OR    = 4'd2,
        OP_SHL1  = 4'd3,
        OP_SHR1  = 4'd4,
        OP_ADD   = 4'd5,
        OP_SUB   = 4'd6,
        OP_PASSA = 4'd7,
        OP_SHLN  = 4'd8,
        OP_SHRN  = 4'd9
    } alu_op_e;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    function automatic logic writes_carry(input logic [3:0] op);
        return (op == OP_SHL1) || (op == OP_SHR1) || (op == OP_ADD) ||
               (op == OP_SUB)  || (op == OP_SHLN) || (op == OP_SHRN);
    endfunction

    function automatic logic is_multishift(input logic [3:0] op);
        return (op == OP_SHLN) || (op == OP_SHRN);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational single-cycle ALU datapath (logic, add/sub, one-bit shift)
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             flag,
    output logic [WIDTH-1:0] rslt,
    output logic             cout,
    output logic             illegal
);

    logic [WIDTH:0] sum;

    always_comb begin
        rslt    = '0;
        cout    = flag;
        illegal = 1'b0;
        sum     = '0;
        case (op)
            OP_AND:   rslt = a & b;
            OP_XOR:   rslt = a ^ b;
            OP_OR:    rslt = a | b;
            OP_PASSA: rslt = a;
            OP_SHL1:  {cout, rslt} = {a, cin};
            OP_SHR1:  {rslt, cout} = {cin, a};
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                {cout, rslt} = sum;
            end
            OP_SUB: begin
                // cout=1 means no borrow
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
                {cout, rslt} = sum;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with carry flag and iterative multi-bit shifter
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_cmd,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin_sel,
    input  logic             shiftcarry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rslt,
    output logic             shiftcarry_out,
    output logic             zero,
    output logic             neg,
    output logic             illegal
);

    logic [0:0]         state;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] cnt;
    logic               dir_left;
    logic               carry_flag;

    logic               accept;
    logic               cin_in;
    logic               multi;
    logic [SHAMT_W-1:0] shamt;

    logic [3:0]         c_op;
    logic [WIDTH-1:0]   c_a;
    logic               c_cin;
    logic [WIDTH-1:0]   c_rslt;
    logic               c_cout;
    logic               c_illegal;

    logic               done;
    logic               d_wc;
    logic [WIDTH-1:0]   d_rslt;
    logic               d_cout;

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign cin_in   = cin_sel ? carry_flag : shiftcarry_in;
    assign multi    = is_multishift(alu_cmd);
    assign shamt    = in_b[SHAMT_W-1:0];

    // The shared datapath does every shift step as a zero-filled one-bit shift.
    always_comb begin
        c_op  = alu_cmd;
        c_a   = in_a;
        c_cin = cin_in;
        if (state == S_SHIFT) begin
            c_op  = dir_left ? OP_SHL1 : OP_SHR1;
            c_a   = work_q;
            c_cin = 1'b0;
        end else if (multi) begin
            c_op  = (alu_cmd == OP_SHLN) ? OP_SHL1 : OP_SHR1;
            c_cin = 1'b0;
        end
    end

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op      (c_op),
        .a       (c_a),
        .b       (in_b),
        .cin     (c_cin),
        .flag    (carry_flag),
        .rslt    (c_rslt),
        .cout    (c_cout),
        .illegal (c_illegal)
    );

    always_comb begin
        done   = 1'b0;
        d_wc   = 1'b0;
        d_rslt = c_rslt;
        d_cout = c_cout;
        if (state == S_SHIFT) begin
            done = (cnt == SHAMT_W'(1));
            d_wc = 1'b1;
        end else if (accept && !(multi && (shamt > SHAMT_W'(1)))) begin
            done = 1'b1;
            d_wc = writes_carry(alu_cmd);
            if (multi && (shamt == '0)) begin
                d_rslt = in_a;
                d_cout = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            work_q         <= '0;
            cnt            <= '0;
            dir_left       <= 1'b0;
            carry_flag     <= 1'b0;
            out_valid      <= 1'b0;
            rslt           <= '0;
            shiftcarry_out <= 1'b0;
            zero           <= 1'b0;
            neg            <= 1'b0;
            illegal        <= 1'b0;
        end else begin
            if (done) begin
                out_valid      <= 1'b1;
                rslt           <= d_rslt;
                shiftcarry_out <= d_cout;
                zero           <= (d_rslt == '0);
                neg            <= d_rslt[WIDTH-1];
                illegal        <= c_illegal && (state == S_IDLE);
                if (d_wc) begin
                    carry_flag <= d_cout;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (accept && multi && (shamt > SHAMT_W'(1))) begin
                        state    <= S_SHIFT;
                        work_q   <= c_rslt;
                        cnt      <= shamt - SHAMT_W'(1);
                        dir_left <= (alu_cmd == OP_SHLN);
                    end
                end
                S_SHIFT: begin
                    work_q <= c_rslt;
                    cnt    <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - table-driven scoreboard bench for alu_seq
module tb_alu_seq;

    typedef struct {
        int         id;
        logic [3:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
        logic       sel;
        logic       cin;
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       n;
        logic       ill;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] alu_cmd = 4'd0;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       cin_sel = 1'b0;
    logic       shiftcarry_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] rslt;
    logic       shiftcarry_out;
    logic       zero;
    logic       neg;
    logic       illegal;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t vecs[22];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_cmd        (alu_cmd),
        .in_a           (in_a),
        .in_b           (in_b),
        .cin_sel        (cin_sel),
        .shiftcarry_in  (shiftcarry_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .rslt           (rslt),
        .shiftcarry_out (shiftcarry_out),
        .zero           (zero),
        .neg            (neg),
        .illegal        (illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h expected=none", rslt);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk($sformatf("vec%0d{rslt,cout,z,n,ill}", e.id),
                    {20'd0, rslt, shiftcarry_out, zero, neg, illegal},
                    {20'd0, e.r, e.c, e.z, e.n, e.ill});
            end
        end
    end

    task automatic send(input vec_t v);
        int g = 0;
        @(negedge clk);
        in_valid = 1'b1;
        alu_cmd = v.cmd; in_a = v.a; in_b = v.b;
        cin_sel = v.sel; shiftcarry_in = v.cin;
        #1;
        while (!in_ready && g < 50) begin
            @(negedge clk); #1; g++;
        end
        if (g >= 50) chk($sformatf("accept_timeout_vec%0d", v.id), 0, 1);
        sb.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || !in_ready) && g < 100) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 100) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int   lat;
        int   seen;
        vec_t v;

        //           id cmd    a      b     sel   cin   r      c     z     n     ill
        vecs[0]  = '{ 0, 4'd5, 8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{ 1, 4'd5, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{ 2, 4'd5, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{ 3, 4'd6, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{ 4, 4'd6, 8'h07, 8'h07, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{ 5, 4'd0, 8'hCC, 8'hAA, 1'b0, 1'b0, 8'h88, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{ 6, 4'd1, 8'hCC, 8'hAA, 1'b0, 1'b0, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{ 7, 4'd2, 8'hCC, 8'hAA, 1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{ 8, 4'd7, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{ 9, 4'd3, 8'h81, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{10, 4'd4, 8'h02, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{11, 4'd4, 8'h80, 8'h00, 1'b0, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{12, 4'd5, 8'h7F, 8'h00, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{13, 4'd8, 8'h81, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{14, 4'd9, 8'h81, 8'h01, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{15, 4'd8, 8'hA5, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{16, 4'd7, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{17, 4'hC, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[18] = '{18, 4'd9, 8'h80, 8'h07, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{19, 4'd5, 8'hFF, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{20, 4'd8, 8'hFF, 8'h07, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{21, 4'd6, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_outputs", {27'd0, rslt == 8'h00, shiftcarry_out, zero, neg, illegal}, {27'd0, 5'b10000});
        chk("reset_in_ready", 32'(in_ready), 1);

        // single-cycle latency on the first op
        send(vecs[0]);
        chk("add_latency_out_valid", 32'(out_valid), 1);
        drain();

        for (int i = 1; i < 22; i++) send(vecs[i]);
        drain();

        // SHLN n=3: three cycles from accept, in_ready low meanwhile
        v = '{100, 4'd8, 8'h81, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0};
        send(v);
        lat = 1;
        seen = 0;
        while (!out_valid && lat < 20) begin
            if (in_ready) seen++;
            @(posedge clk); #1; lat++;
        end
        chk("shln3_latency", lat, 3);
        chk("shln3_in_ready_low", seen, 0);
        drain();

        // consumer stall: result and flags held, new requests ignored
        @(posedge clk); #1 out_ready = 1'b0;
        v = '{101, 4'd0, 8'hCC, 8'hAA, 1'b0, 1'b0, 8'h88, 1'b0, 1'b0, 1'b1, 1'b0};
        send(v);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; alu_cmd = 4'd5; in_a = 8'h11; in_b = 8'h22;
            @(negedge clk);
            chk($sformatf("stall%0d_hold", i), {22'd0, out_valid, in_ready, rslt, shiftcarry_out, neg},
                {22'd0, 1'b1, 1'b0, 8'h88, 1'b0, 1'b1});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_out_valid", 32'(out_valid), 0);
        chk("stall_no_extra_result", sb.size(), 0);
        drain();

        // reset during SHIFT cycle 2 aborts and clears the flag
        v = '{102, 4'd5, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        send(v);
        drain();
        @(negedge clk);
        in_valid = 1'b1; alu_cmd = 4'd8; in_a = 8'hFF; in_b = 8'h07;
        cin_sel = 1'b0; shiftcarry_in = 1'b0;
        #1 chk("shln7_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("abort_no_result", seen, 0);
        v = '{103, 4'd7, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        send(v);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
